// File: rtl/case3_vector_sequencer.sv
// case3_vector_sequencer: applies vectors to the case3 cone, waits SETTLE cycles, then folds {x,y,z} into a MISR and ones counters.
// Optional built-in golden model of the cone and error reporting: define CASE3_GOLDEN_CHECK_EN.
module case3_vector_sequencer #(
  parameter int unsigned      SETTLE   = 1,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h8016,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             single,
  input  logic [6:0]       vec_in,
  output logic [6:0]       dut_in,
  input  logic [2:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             smp_valid,
  output logic [6:0]       smp_vec,
  output logic [2:0]       smp_data,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_y,
  output logic [CNT_W-1:0] cnt_z
`ifdef CASE3_GOLDEN_CHECK_EN
  ,
  output logic [7:0]       err_cnt,
  output logic             err_flag,
  output logic [6:0]       err_vec
`endif
);

  // state     | meaning
  // S_IDLE    | waiting for start; dut_in holds the last vector
  // S_APPLY   | dut_in stable, settle timer loaded
  // S_SETTLE  | settle timer counts down to terminal count
  // S_CAPTURE | sample dut_out, update MISR/counters, pick next vector
  // S_DONE    | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic       single_q;
  logic [3:0] settle_cnt;
  logic       last_vec;
  logic       run_go;

  assign last_vec = single_q || (dut_in == 7'h7F);
  assign run_go   = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = S_APPLY;
      S_APPLY: begin
        busy     = 1'b1;
        state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy     = 1'b1;
        state_nx = last_vec ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      single_q   <= 1'b0;
      dut_in     <= '0;
      settle_cnt <= '0;
      smp_valid  <= 1'b0;
      smp_vec    <= '0;
      smp_data   <= '0;
      sig        <= '1;
      cnt_x      <= '0;
      cnt_y      <= '0;
      cnt_z      <= '0;
    end else begin
      smp_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          single_q <= single;
          dut_in   <= single ? vec_in : 7'd0;
          sig      <= '1;
          cnt_x    <= '0;
          cnt_y    <= '0;
          cnt_z    <= '0;
        end
        S_APPLY:  settle_cnt <= SETTLE_LD;
        S_SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        S_CAPTURE: begin
          smp_valid <= 1'b1;
          smp_vec   <= dut_in;
          smp_data  <= dut_out;
          sig       <= (sig >> 1) ^ (sig[0] ? SIG_POLY : '0) ^ {{(SIG_W-3){1'b0}}, dut_out};
          cnt_x     <= cnt_x + CNT_W'(dut_out[2]);
          cnt_y     <= cnt_y + CNT_W'(dut_out[1]);
          cnt_z     <= cnt_z + CNT_W'(dut_out[0]);
          if (!last_vec) dut_in <= dut_in + 7'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef CASE3_GOLDEN_CHECK_EN
  function automatic logic [2:0] cone_model(input logic [6:0] v);
    logic a, b, c, d, e, f, g, x, y, z;
    {a, b, c, d, e, f, g} = v;
    x = a & b & c & d & e;
    y = b | c | (d ^ f) | (e ^ g);
    z = d ? (((e & g) | ~c) & ~(a & b & e & g)) : ((a & b & e & g) | (c & ~(e & g)));
    return {x, y, z};
  endfunction

  logic mismatch;
  assign mismatch = (state == S_CAPTURE) && (dut_out != cone_model(dut_in));

  // err_vec captures only the first mismatch of a run; err_flag gates later ones.
  always_ff @(posedge clk) begin
    if (rst || run_go) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
      err_vec  <= '0;
    end else if (mismatch) begin
      err_cnt  <= err_cnt + 8'd1;
      err_flag <= 1'b1;
      if (!err_flag) err_vec <= dut_in;
    end
  end
`endif

endmodule
